// File: rtl/conv_transpose2d_scatter_acc.sv
// conv_transpose2d_scatter_acc
// Streaming 2D transposed convolution for one input channel and one output
// channel per pass. Each input pixel is scattered through the kernel into an
// internal OH x OW accumulator. Passes may be chained without clearing, so
// several input channels sum into the same plane before it is drained.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, clear, drain    pass request; clear/drain are sampled with start
//   busy, done             pass in progress / one-cycle end-of-pass pulse
//   weight_valid/ready/data  kernel taps, kh-major then kw
//   valid_in/ready_in/input_data  input pixels, raster order
//   valid_out/ready_out/output_data/last_out  accumulator drain, raster order
module conv_transpose2d_scatter_acc #(
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int IH    = 4,
  parameter int IW    = 5,
  parameter int KH    = 3,
  parameter int KW    = 2,
  parameter int SH    = 2,
  parameter int SW    = 3,
  parameter int PH    = 1,
  parameter int PW    = 0,
  parameter int DLH   = 2,
  parameter int DLW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    drain,
  output logic                    busy,
  input  logic                    weight_valid,
  output logic                    weight_ready,
  input  logic signed [DW-1:0]    weight_data,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [DW-1:0]    input_data,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [ACC_W-1:0] output_data,
  output logic                    last_out,
  output logic                    done
);

  localparam int OH   = (IH-1)*SH - 2*PH + DLH*(KH-1) + 1;
  localparam int OW   = (IW-1)*SW - 2*PW + DLW*(KW-1) + 1;
  localparam int NOUT = OH*OW;
  localparam int NTAP = KH*KW;
  localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int CW   = 16;

  localparam logic [AW-1:0] LAST_IDX = AW'(NOUT-1);
  localparam logic [CW-1:0] KH_M1    = CW'(KH-1);
  localparam logic [CW-1:0] KW_M1    = CW'(KW-1);
  localparam logic [CW-1:0] IH_M1    = CW'(IH-1);
  localparam logic [CW-1:0] IW_M1    = CW'(IW-1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_W, S_WAIT_PIX, S_SCATTER, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic          drn_q, drn_d;
  logic          done_q, done_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] kh_q, kh_d, kw_q, kw_d;
  logic [CW-1:0] ih_q, ih_d, iw_q, iw_d;

  logic signed [DW-1:0]    x_p0;
  logic signed [DW-1:0]    w_mem   [NTAP];
  logic signed [ACC_W-1:0] acc_mem [NOUT];

  logic                    acc_we;
  logic [AW-1:0]           acc_addr;
  logic signed [ACC_W-1:0] acc_wdata;
  logic [AW-1:0]           tgt_addr;
  logic [TW-1:0]           tap;
  logic                    tap_last;
  logic                    step_tap;
  int                      oh_t, ow_t;

  // Full-precision signed product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    return ACC_W'(p);
  endfunction

  // Accumulation wraps modulo 2^ACC_W; no saturation.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    return a + b;
  endfunction

  assign tap      = TW'(int'(kh_q)*KW + int'(kw_q));
  assign tap_last = (kh_q == KH_M1) && (kw_q == KW_M1);

  always_comb begin
    state_d   = state_q;
    drn_d     = drn_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    kh_d      = kh_q;
    kw_d      = kw_q;
    ih_d      = ih_q;
    iw_d      = iw_q;
    step_tap  = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = idx_q;
    acc_wdata = '0;
    oh_t      = int'(ih_q)*SH - PH + int'(kh_q)*DLH;
    ow_t      = int'(iw_q)*SW - PW + int'(kw_q)*DLW;
    tgt_addr  = AW'(oh_t*OW + ow_t);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          drn_d   = drain;
          idx_d   = '0;
          kh_d    = '0;
          kw_d    = '0;
          ih_d    = '0;
          iw_d    = '0;
          state_d = clear ? S_CLEAR : S_LOAD_W;
        end
      end
      S_CLEAR: begin
        acc_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_LOAD_W;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_LOAD_W: begin
        if (weight_valid) begin
          step_tap = 1'b1;
          if (tap_last) state_d = S_WAIT_PIX;
        end
      end
      S_WAIT_PIX: begin
        if (valid_in) state_d = S_SCATTER;
      end
      S_SCATTER: begin
        step_tap = 1'b1;
        // Out-of-plane taps still spend their cycle, only the write is dropped.
        if (oh_t >= 0 && oh_t < OH && ow_t >= 0 && ow_t < OW) begin
          acc_we    = 1'b1;
          acc_addr  = tgt_addr;
          acc_wdata = acc_add(acc_mem[tgt_addr], mul_ext(x_p0, w_mem[tap]));
        end
        if (tap_last) begin
          if (ih_q == IH_M1 && iw_q == IW_M1) begin
            ih_d = '0;
            iw_d = '0;
            if (drn_q) begin
              idx_d   = '0;
              state_d = S_DRAIN;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_WAIT_PIX;
            if (iw_q == IW_M1) begin
              iw_d = '0;
              ih_d = ih_q + CW'(1);
            end else begin
              iw_d = iw_q + CW'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (ready_out) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Tap counter walks kh outer, kw inner for both weight load and scatter.
    if (step_tap) begin
      if (kw_q == KW_M1) begin
        kw_d = '0;
        kh_d = (kh_q == KH_M1) ? '0 : kh_q + CW'(1);
      end else begin
        kw_d = kw_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drn_q   <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      kh_q    <= '0;
      kw_q    <= '0;
      ih_q    <= '0;
      iw_q    <= '0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      kh_q    <= kh_d;
      kw_q    <= kw_d;
      ih_q    <= ih_d;
      iw_q    <= iw_d;
    end
  end

  // Data storage: kernel, latched pixel and accumulator plane
  always_ff @(posedge clk) begin
    if (acc_we) acc_mem[acc_addr] <= acc_wdata;
    if (state_q == S_LOAD_W && weight_valid) w_mem[tap] <= weight_data;
    if (state_q == S_WAIT_PIX && valid_in) x_p0 <= input_data;
  end

  assign busy         = (state_q != S_IDLE);
  assign weight_ready = (state_q == S_LOAD_W);
  assign ready_in     = (state_q == S_WAIT_PIX);
  assign valid_out    = (state_q == S_DRAIN);
  assign last_out     = valid_out && (idx_q == LAST_IDX);
  assign output_data  = valid_out ? acc_mem[idx_q] : '0;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_transpose2d_scatter_acc.sv
module tb_conv_transpose2d_scatter_acc;

  localparam int DW = 16, ACC_W = 40;
  localparam int IH = 4, IW = 5, KH = 3, KW = 2, SH = 2, SW = 3;
  localparam int PH = 1, PW = 0, DLH = 2, DLW = 1;
  localparam int OH = 9, OW = 14, NOUT = OH*OW, NTAP = KH*KW, NPIX = IH*IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, clear = 1'b0, drain = 1'b0;
  logic busy, done;
  logic weight_valid = 1'b0, weight_ready;
  logic signed [DW-1:0] weight_data = '0;
  logic valid_in = 1'b0, ready_in;
  logic signed [DW-1:0] input_data = '0;
  logic valid_out, last_out;
  logic ready_out = 1'b1;
  logic signed [ACC_W-1:0] output_data;

  always #5 clk = ~clk;

  conv_transpose2d_scatter_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .drain(drain),
    .busy(busy), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .weight_data(weight_data), .valid_in(valid_in), .ready_in(ready_in),
    .input_data(input_data), .valid_out(valid_out), .ready_out(ready_out),
    .output_data(output_data), .last_out(last_out), .done(done)
  );

  int checks = 0;
  int failures = 0;
  logic [ACC_W-1:0] model     [NOUT];
  logic [ACC_W-1:0] got_plane [NOUT];
  logic [ACC_W-1:0] od_c;
  int  exp_idx = 0;
  int  drained_cnt = 0;
  bit  expect_drain = 1'b0;
  int  wv [NTAP];
  int  pv [NPIX];
  bit  rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: scatter every pixel through every kernel tap into the plane.
  function automatic void model_pass(input bit c);
    int oh, ow;
    longint p;
    if (c) foreach (model[i]) model[i] = '0;
    for (int ih = 0; ih < IH; ih++)
      for (int iw = 0; iw < IW; iw++)
        for (int kh = 0; kh < KH; kh++)
          for (int kw = 0; kw < KW; kw++) begin
            oh = ih*SH - PH + kh*DLH;
            ow = iw*SW - PW + kw*DLW;
            if (oh >= 0 && oh < OH && ow >= 0 && ow < OW) begin
              p = longint'(pv[ih*IW+iw]) * longint'(wv[kh*KW+kw]);
              model[oh*OW+ow] = model[oh*OW+ow] + ACC_W'(p);
            end
          end
  endfunction

  // Output and handshake checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hs_exclusive", 64'($countones({weight_ready, ready_in, valid_out}) > 1), 64'(0));
      chk("done_vs_busy", 64'(done && busy), 64'(0));
      if (valid_out) begin
        if (!expect_drain || exp_idx >= NOUT) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid_out got=1 exp=0 idx=%0d", exp_idx);
        end else begin
          od_c = output_data;
          chk("out_data", 64'(od_c), 64'(model[exp_idx]));
          chk("last_out", 64'(last_out), 64'(exp_idx == NOUT-1));
          if (ready_out) begin
            got_plane[exp_idx] = od_c;
            exp_idx++;
            drained_cnt++;
          end
        end
      end else begin
        chk("last_out_idle", 64'(last_out), 64'(0));
      end
    end
  end

  task automatic do_start(input bit c, input bit d);
    int n;
    expect_drain = d;
    exp_idx = 0;
    drained_cnt = 0;
    start = 1'b1; clear = c; drain = d;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'(~c); drain = 1'(~d);
    n = 1;
    while (!weight_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wready_latency", 64'(n), 64'(c ? NOUT+1 : 1));
  endtask

  task automatic send_weights();
    int k, g;
    bit acc;
    k = 0; g = 0;
    while (k < NTAP && g < 2000) begin
      weight_valid = ($urandom_range(0, 3) != 0);
      weight_data  = DW'(wv[k]);
      acc = weight_valid && weight_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    weight_valid = 1'b0;
    if (k < NTAP) begin
      checks++; failures++;
      $display("FAIL weight_timeout got=%0d exp=%0d", k, NTAP);
    end
  endtask

  task automatic send_pixels(input int cnt);
    int i, g;
    bit acc;
    i = 0; g = 0;
    while (i < cnt && g < 4000) begin
      valid_in   = ($urandom_range(0, 3) != 0);
      input_data = DW'(pv[i]);
      acc = valid_in && ready_in;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    valid_in = 1'b0;
    if (i < cnt) begin
      checks++; failures++;
      $display("FAIL pixel_timeout got=%0d exp=%0d", i, cnt);
    end
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern plus a start while busy, 2: random
  task automatic wait_done(input int mode, input bit check_tail);
    int g;
    bit seen;
    g = 0; seen = 1'b0;
    while (!seen && g < 1000) begin
      if (mode == 1) ready_out = rpat[g%4];
      else if (mode == 2) ready_out = ($urandom_range(0, 3) != 0);
      else ready_out = 1'b1;
      if (mode == 1 && g == 20) begin
        start = 1'b1; clear = 1'b1; drain = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      g++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("busy_at_done", 64'(busy), 64'(0));
    if (check_tail) chk("done_latency", 64'(g), 64'(NTAP));
    chk("drain_count", 64'(drained_cnt), 64'(expect_drain ? NOUT : 0));
    ready_out = 1'b1;
    @(posedge clk); #1;
    chk("done_single", 64'(done), 64'(0));
  endtask

  task automatic run_pass(input bit c, input bit d, input int mode);
    model_pass(c);
    do_start(c, d);
    send_weights();
    send_pixels(NPIX);
    wait_done(mode, !d);
  endtask

  task automatic fill_random();
    foreach (wv[i]) wv[i] = int'($urandom_range(0, 65535)) - 32768;
    foreach (pv[i]) pv[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_wready"}, 64'(weight_ready), 64'(0));
    chk({tag, "_ready_in"}, 64'(ready_in), 64'(0));
    chk({tag, "_valid_out"}, 64'(valid_out), 64'(0));
    chk({tag, "_last_out"}, 64'(last_out), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    od_c = output_data;
    chk({tag, "_data"}, 64'(od_c), 64'(0));
  endtask

  initial begin
    @(posedge clk); #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse: only w[0][0]=1, x = ih*5+iw+1
    foreach (wv[i]) wv[i] = 0;
    wv[0] = 1;
    foreach (pv[i]) pv[i] = i + 1;
    run_pass(1'b1, 1'b1, 0);
    chk("impulse_model_1_0", 64'(model[14]), 64'(6));
    chk("impulse_dut_1_0", 64'(got_plane[14]), 64'(6));
    chk("impulse_dut_5_12", 64'(got_plane[82]), 64'(20));
    chk("impulse_dut_0_0", 64'(got_plane[0]), 64'(0));

    // Overlap: all ones; (1,0) collects (ih=0,kh=1) and (ih=1,kh=0)
    foreach (wv[i]) wv[i] = 1;
    foreach (pv[i]) pv[i] = 1;
    run_pass(1'b1, 1'b1, 2);
    chk("overlap_model_3_1", 64'(model[43]), 64'(3));
    chk("overlap_dut_3_1", 64'(got_plane[43]), 64'(3));
    chk("overlap_dut_0_0", 64'(got_plane[0]), 64'(0));
    chk("overlap_dut_1_0", 64'(got_plane[14]), 64'(2));

    // Signed extreme: (-32768) * (-1) must stay positive at 40 bits
    foreach (wv[i]) wv[i] = 0;
    wv[0] = -1;
    foreach (pv[i]) pv[i] = 0;
    pv[5] = -32768;
    run_pass(1'b1, 1'b1, 0);
    chk("signed_model_1_0", 64'(model[14]), 64'(40'h00_0000_8000));
    chk("signed_dut_1_0", 64'(got_plane[14]), 64'(40'h00_0000_8000));

    // Chained passes, second one drained under 1,0,0,1 backpressure
    foreach (wv[i]) wv[i] = 1;
    foreach (pv[i]) pv[i] = 1;
    run_pass(1'b1, 1'b0, 0);
    run_pass(1'b0, 1'b1, 1);
    chk("chain_model_3_1", 64'(model[43]), 64'(6));
    chk("chain_dut_3_1", 64'(got_plane[43]), 64'(6));

    // Reset while scattering the first pixel
    fill_random();
    do_start(1'b0, 1'b1);
    send_weights();
    send_pixels(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    expect_drain = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(1'b1, 1'b1, 2);

    // Randomised passes, chained when clear is 0
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_pass((it == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
               (it == 5) ? 1'b1 : 1'($urandom_range(0, 1)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
